// File: rtl/mem_reg_16_arb_if.sv
// Bus bundle for the register-file write-port arbiter: host port, internal
// requesters and the single register-file port it drives.
interface mem_reg_16_arb_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 5,
  parameter int DW    = 16
);
  logic               host_we;
  logic               host_re;
  logic [AW-1:0]      host_addr;
  logic [DW-1:0]      host_din;
  logic [DW-1:0]      host_dout;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic               mem_we;
  logic               mem_re;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_din;
  logic [DW-1:0]      mem_dout;
  logic               starve;
  logic               host_preempt;

  modport slave (
    input  host_we, host_re, host_addr, host_din, req, req_addr, req_data, mem_dout,
    output host_dout, ack, mem_we, mem_re, mem_addr, mem_din, starve, host_preempt
  );

  modport master (
    output host_we, host_re, host_addr, host_din, req, req_addr, req_data, mem_dout,
    input  host_dout, ack, mem_we, mem_re, mem_addr, mem_din, starve, host_preempt
  );
endinterface

// File: rtl/mem_reg_16_arb.sv
// Write-port arbiter for the host control/status register file: host has
// absolute priority, internal status reporters share leftover cycles round-robin.
//
// state | meaning
// IDLE  | no internal grant held; latch one if any req is set
// WRITE | grant gnt held; writes it on the first host-idle cycle
module mem_reg_16_arb #(
  parameter int N_REQ      = 4,
  parameter int AW         = 5,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_reg_16_arb_if.slave  bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    gnt, gnt_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [SW-1:0]    starve_cnt, starve_cnt_nxt;
  logic             host_act;
  logic [N_REQ-1:0] req_avail;
  logic [IW-1:0]    search_base;
  logic [IW-1:0]    sel_idx;
  logic             sel_found;
  int               search_idx;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    return IW'((int'(v) + 1) % N_REQ);
  endfunction

  assign host_act      = bus.host_we | bus.host_re;
  assign bus.host_dout = bus.mem_dout;
  assign bus.starve    = (starve_cnt == SW'(STARVE_MAX));

  // While writing, the current grant is excluded so the next pick can chain
  // back-to-back without re-granting the requester that is being acked.
  always_comb begin
    req_avail   = bus.req;
    search_base = ptr;
    if (state == WRITE) begin
      req_avail[gnt] = 1'b0;
      search_base    = inc_mod(gnt);
    end
  end

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    search_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      search_idx = (int'(search_base) + k) % N_REQ;
      if (!sel_found && req_avail[search_idx]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(search_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      ptr        <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      ptr        <= ptr_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    ptr_nxt        = ptr;
    starve_cnt_nxt = starve_cnt;
    case (state)
      IDLE: begin
        starve_cnt_nxt = '0;
        if (sel_found) begin
          gnt_nxt   = sel_idx;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (host_act) begin
          if (starve_cnt != SW'(STARVE_MAX))
            starve_cnt_nxt = starve_cnt + SW'(1);
        end else begin
          ptr_nxt        = inc_mod(gnt);
          starve_cnt_nxt = '0;
          if (sel_found)
            gnt_nxt = sel_idx;
          else
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Host traffic is a pure pass-through so it sees the bare file latency.
  always_comb begin
    bus.mem_we       = 1'b0;
    bus.mem_re       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_din      = '0;
    bus.ack          = '0;
    bus.host_preempt = 1'b0;
    if (host_act) begin
      bus.mem_we       = bus.host_we;
      bus.mem_re       = bus.host_re;
      bus.mem_addr     = bus.host_addr;
      bus.mem_din      = bus.host_din;
      bus.host_preempt = (state == WRITE);
    end else if (state == WRITE) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = bus.req_addr[int'(gnt)*AW +: AW];
      bus.mem_din  = bus.req_data[int'(gnt)*DW +: DW];
      bus.ack[gnt] = 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_reg_16_arb.sv
// Bench for mem_reg_16_arb: directed scenarios plus random traffic, checked
// every cycle against a transaction-level arbitration model and a shadow register file.
module tb_mem_reg_16_arb;
  localparam int N    = 4;
  localparam int AW   = 5;
  localparam int DW   = 16;
  localparam int SMAX = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_reg_16_arb_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();
  mem_reg_16_arb #(.N_REQ(N), .AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file behind the port: write at the edge, registered read.
  logic [DW-1:0] regs [32] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_we) regs[bus.mem_addr] <= bus.mem_din;
    if (bus.mem_re) bus.mem_dout <= regs[bus.mem_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_find(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  // Model: at most one grant outstanding, a round-robin start point, and a
  // count of host-blocked cycles for the outstanding grant.
  bit            m_pend, n_pend;
  int            m_idx, n_idx, m_ptr, n_ptr, m_blk, n_blk;
  logic [DW-1:0] exp_mem [32] = '{default: '0};
  bit            rd_pend;
  logic [DW-1:0] rd_exp;
  bit            w_en;
  int            w_addr;
  logic [DW-1:0] w_data;
  logic [N-1:0]  ack_seen = '0;
  logic          ha, e_we, e_re;
  logic [N-1:0]  e_ack;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  int            f;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend = 0; m_idx = 0; m_ptr = 0; m_blk = 0;
      n_pend = 0; n_idx = 0; n_ptr = 0; n_blk = 0;
      rd_pend = 0; w_en = 0;
      if (!(bus.host_we | bus.host_re)) begin
        check("rst_ack", bus.ack, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_starve", bus.starve, 0);
        check("rst_preempt", bus.host_preempt, 0);
      end
    end else begin
      if (rd_pend) check("host_dout", bus.host_dout, rd_exp);
      ha     = bus.host_we | bus.host_re;
      e_ack  = (m_pend && !ha) ? (N'(1) << m_idx) : '0;
      e_we   = ha ? bus.host_we : m_pend;
      e_re   = ha ? bus.host_re : 1'b0;
      e_addr = ha ? bus.host_addr : bus.req_addr[m_idx*AW +: AW];
      e_din  = ha ? bus.host_din  : bus.req_data[m_idx*DW +: DW];
      check("ack", bus.ack, e_ack);
      check("mem_we", bus.mem_we, e_we);
      check("mem_re", bus.mem_re, e_re);
      if (e_we || e_re) check("mem_addr", bus.mem_addr, e_addr);
      if (e_we) check("mem_din", bus.mem_din, e_din);
      check("host_preempt", bus.host_preempt, m_pend && ha);
      check("starve", bus.starve, m_blk == SMAX);
      rd_pend = ha && bus.host_re;
      if (rd_pend) rd_exp = exp_mem[bus.host_addr];
      w_en = e_we; w_addr = int'(e_addr); w_data = e_din;
      n_pend = m_pend; n_idx = m_idx; n_ptr = m_ptr; n_blk = m_blk;
      if (m_pend && ha) begin
        n_blk = (m_blk < SMAX) ? m_blk + 1 : SMAX;
      end else if (m_pend) begin
        n_ptr = (m_idx + 1) % N;
        n_blk = 0;
        f = rr_find(bus.req & ~(N'(1) << m_idx), n_ptr);
        n_pend = (f >= 0);
        if (f >= 0) n_idx = f;
      end else begin
        n_blk = 0;
        f = rr_find(bus.req, m_ptr);
        if (f >= 0) begin n_pend = 1; n_idx = f; end
      end
    end
    ack_seen = bus.ack;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_pend = n_pend; m_idx = n_idx; m_ptr = n_ptr; m_blk = n_blk;
      if (w_en) exp_mem[w_addr] = w_data;
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i] = 1'b1;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  // One clock: acked requesters drop (or, in random mode, sometimes re-request).
  task automatic cycle(input bit rnd);
    int r;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i]) begin
        if (rnd && $urandom_range(3) == 0) set_req(i, AW'($urandom), DW'($urandom));
        else bus.req[i] = 1'b0;
      end else if (rnd && !bus.req[i] && $urandom_range(2) == 0) begin
        set_req(i, AW'($urandom), DW'($urandom));
      end
    end
    if (rnd) begin
      r = $urandom_range(9);
      bus.host_we   = (r < 2);
      bus.host_re   = (r >= 2 && r < 4);
      bus.host_addr = AW'($urandom);
      bus.host_din  = DW'($urandom);
    end
  endtask

  task automatic host_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    @(posedge clk); #1;
    bus.host_re = 1'b1; bus.host_addr = a;
    @(posedge clk); #1;
    bus.host_re = 1'b0;
    @(negedge clk);
    check(name, bus.host_dout, exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.host_we = 0; bus.host_re = 0; bus.req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.host_we = 0; bus.host_re = 0; bus.host_addr = '0; bus.host_din = '0;
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ack", bus.ack, 0);
    check("reset_mem_we", bus.mem_we, 0);
    check("reset_mem_re", bus.mem_re, 0);
    check("reset_starve", bus.starve, 0);

    // Single write with 1-cycle latency, then read back.
    @(posedge clk); #1 set_req(2, 5'h10, 16'h1234);
    @(negedge clk); check("sw_c0_ack", bus.ack, 0);
    cycle(0); @(negedge clk);
    check("sw_ack", bus.ack, 4'b0100);
    check("sw_we", bus.mem_we, 1);
    check("sw_addr", bus.mem_addr, 5'h10);
    cycle(0); @(negedge clk); check("sw_after", bus.ack, 0);
    host_rd(5'h10, 16'h1234, "sw_readback");

    // Round-robin from ptr 0, one ack per cycle.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, AW'(4 + i), DW'(16'hA0 + i));
    for (int c = 0; c < N; c++) begin
      cycle(0); @(negedge clk);
      check("rr_order", bus.ack, N'(1) << c);
    end
    cycle(0); @(negedge clk); check("rr_nodup", bus.ack, 0);

    // Host preempts a pending grant for three cycles.
    @(posedge clk); #1 set_req(1, 5'h07, 16'hBEEF);
    @(posedge clk); #1 bus.host_we = 1; bus.host_addr = 5'h00; bus.host_din = 16'h0001;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("pre_preempt", bus.host_preempt, 1);
      check("pre_noack", bus.ack, 0);
      if (c < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 bus.host_we = 0;
    @(negedge clk);
    check("pre_ack", bus.ack, 4'b0010);
    check("pre_addr", bus.mem_addr, 5'h07);
    cycle(0);
    host_rd(5'h00, 16'h0001, "pre_reg0");
    host_rd(5'h07, 16'hBEEF, "pre_reg7");

    // Starvation under a 70-cycle host read burst.
    @(posedge clk); #1 set_req(0, 5'h03, 16'h5A5A);
    @(posedge clk); #1 bus.host_re = 1; bus.host_addr = 5'h00;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 60) check("stv_low", bus.starve, 0);
      if (k == 66 || k == 70) check("stv_high", bus.starve, 1);
      if (k < 70) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 bus.host_re = 0;
    @(negedge clk); check("stv_ack", bus.ack, 4'b0001);
    cycle(0); @(negedge clk); check("stv_clear", bus.starve, 0);

    // Mask and wrap from ptr 3.
    @(posedge clk); #1 set_req(2, 5'h09, 16'h2222);
    cycle(0); @(negedge clk); check("mw_setup", bus.ack, 4'b0100);
    cycle(0);
    @(posedge clk); #1 set_req(0, 5'h01, 16'h0A0A); set_req(3, 5'h02, 16'h3333);
    cycle(0); @(negedge clk); check("mw_first", bus.ack, 4'b1000);
    cycle(0); set_req(3, 5'h02, 16'h3334);
    @(negedge clk); check("mw_second", bus.ack, 4'b0001);
    cycle(0); @(negedge clk); check("mw_rereq", bus.ack, 4'b1000);
    cycle(0); @(negedge clk); check("mw_idle", bus.ack, 0);

    // Reset while a starved grant is pending.
    @(posedge clk); #1 set_req(1, 5'h0C, 16'hC0DE);
    @(posedge clk); #1 bus.host_re = 1; bus.host_addr = 5'h01;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      if (k < 66) begin @(posedge clk); #1; end
    end
    check("rmw_starve_pre", bus.starve, 1);
    @(posedge clk); #2 rst_n = 1'b0; bus.req = '0;
    #1;
    check("rmw_ack", bus.ack, 0);
    check("rmw_we", bus.mem_we, 0);
    check("rmw_starve", bus.starve, 0);
    check("rmw_preempt", bus.host_preempt, 0);
    bus.host_re = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, AW'(20 + i), DW'(16'hD00 + i));
    cycle(0); @(negedge clk); check("rmw_ptr0", bus.ack, 4'b0001);
    repeat (5) cycle(0);

    // Random traffic with one reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      cycle(1);
    end
    @(posedge clk); #1 bus.host_we = 0; bus.host_re = 0;
    repeat (10) cycle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
